// File: rtl/pb_pulse_generator.sv
// Push-button front end: 2-flop synchronizer, debounce filter and a press/hold/auto-repeat
// state machine producing registered single-cycle strobes for the counter chain.
module pb_pulse_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic pb_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step,
  output logic held
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmrMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] HoldLast = TmrW'(HOLD_CYCLES - 1);
  localparam logic [TmrW-1:0] RepLast  = TmrW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressed, StRepeating} state_e;

  logic            s1_q, s2_q;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            rise, fall;
  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            repeat_q, repeat_d;
  logic            step_q, held_q, held_d;

  // Debounce: the level flips on the edge the mismatch count would reach DEBOUNCE_CYCLES.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (s2_q != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  // Strobes react to the debounced edge in the same cycle the level changes.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    if (fall) begin
      // Release takes priority over any timer expiry on the same edge.
      state_d   = StIdle;
      tmr_d     = '0;
      release_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            press_d = 1'b1;
            state_d = StPressed;
            tmr_d   = '0;
          end
        end
        StPressed: begin
          if (tmr_q == HoldLast) begin
            repeat_d = 1'b1;
            state_d  = StRepeating;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        StRepeating: begin
          if (tmr_q == RepLast) begin
            repeat_d = 1'b1;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          tmr_d   = '0;
        end
      endcase
    end
    held_d = (state_d == StRepeating);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= StIdle;
      tmr_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      s1_q      <= pb;
      s2_q      <= s1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      step_q    <= press_d | repeat_d;
      held_q    <= held_d;
    end
  end

  assign pb_level      = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step          = step_q;
  assign held          = held_q;

endmodule

// File: tb/tb_pb_pulse_generator.sv
// Bench for pb_pulse_generator: directed scenarios plus random button activity, all checked
// against an event-level reference model (sample history window and press-age arithmetic).
module tb_pb_pulse_generator;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb  = 1'b0;
  logic pb_level, press_pulse, release_pulse, repeat_pulse, step, held;

  pb_pulse_generator #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pb           (pb),
    .pb_level     (pb_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .step         (step),
    .held         (held)
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_err  = 0;
  int   edge_n = 0;

  // Reference model state
  logic pb_hist[$];
  logic dsamp[$];
  logic m_lvl = 1'b0, m_pressed = 1'b0;
  int   m_pt = 0;
  logic e_press = 1'b0, e_rel = 1'b0, e_rep = 1'b0, e_held = 1'b0;

  function automatic logic [5:0] got();
    return {pb_level, press_pulse, release_pulse, repeat_pulse, step, held};
  endfunction

  function automatic logic [5:0] want();
    return {m_lvl, e_press, e_rel, e_rep, e_press | e_rep, e_held};
  endfunction

  // The level flips once the last D filter samples (pb delayed two edges) all disagree with it.
  // Repeats fire when the age since press is H, H+R, H+2R, ...
  task automatic model_edge(input logic p, input logic r);
    logic smp, all_diff;
    int   age;
    edge_n++;
    e_press = 1'b0; e_rel = 1'b0; e_rep = 1'b0; e_held = 1'b0;
    if (r) begin
      pb_hist.delete();
      dsamp.delete();
      m_lvl     = 1'b0;
      m_pressed = 1'b0;
    end else begin
      smp = (pb_hist.size() >= 2) ? pb_hist[pb_hist.size()-2] : 1'b0;
      pb_hist.push_back(p);
      if (pb_hist.size() > 8) void'(pb_hist.pop_front());
      dsamp.push_back(smp);
      if (dsamp.size() > D) void'(dsamp.pop_front());
      all_diff = (dsamp.size() == D);
      foreach (dsamp[i]) if (dsamp[i] == m_lvl) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl = ~m_lvl;
        if (m_lvl) begin
          e_press = 1'b1; m_pressed = 1'b1; m_pt = edge_n;
        end else begin
          e_rel = 1'b1; m_pressed = 1'b0;
        end
      end else if (m_pressed) begin
        age    = edge_n - m_pt;
        e_rep  = (age >= H) && ((age - H) % R == 0);
        e_held = (age >= H);
      end
    end
  endtask

  task automatic tick(input logic p, input logic r);
    pb  = p;
    rst = r;
    @(posedge clk);
    model_edge(p, r);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      n_vec++;
      if (got() !== 6'b0) begin
        n_err++; $display("FAIL reset_outputs edge %0d: got %b want %b", edge_n, got(), 6'b0);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if (press_pulse !== (i == 6)) begin
        n_err++; $display("FAIL reset_press_time edge %0d: got %b want %b", i, press_pulse, i == 6);
      end
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL reset_model edge %0d: got %b want %b", edge_n, got(), want());
      end
    end
    n_vec++;
    if (pb_level !== 1'b1) begin
      n_err++; $display("FAIL reset_level: got %b want 1", pb_level);
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL clean_idle edge %0d: got %b want %b", edge_n, got(), want());
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if ({press_pulse, step, held} !== {i == 6, i == 6, 1'b0}) begin
        n_err++; $display("FAIL clean_press edge %0d: got %b%b%b want %b%b0", i, press_pulse,
                          step, held, i == 6, i == 6);
      end
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL clean_model edge %0d: got %b want %b", edge_n, got(), want());
      end
    end
    for (int i = 1; i <= 10; i++) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if ({release_pulse, repeat_pulse} !== {i == 6, 1'b0}) begin
        n_err++; $display("FAIL clean_release edge %0d: got %b%b want %b0", i, release_pulse,
                          repeat_pulse, i == 6);
      end
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL clean_model edge %0d: got %b want %b", edge_n, got(), want());
      end
    end
  endtask

  task automatic test_bounce();
    int presses = 0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick((j < 2) ? 1'b1 : 1'b0, 1'b0);
        if (press_pulse === 1'b1) presses++;
        n_vec++;
        if (got() !== want()) begin
          n_err++; $display("FAIL bounce_model edge %0d: got %b want %b", edge_n, got(), want());
        end
      end
    end
    n_vec++;
    if (presses != 0) begin
      n_err++; $display("FAIL bounce_reject: got %0d presses want 0", presses);
    end
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0);
      n_vec++;
      if (press_pulse !== (i == 6)) begin
        n_err++; $display("FAIL bounce_press edge %0d: got %b want %b", i, press_pulse, i == 6);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL bounce_model edge %0d: got %b want %b", edge_n, got(), want());
      end
    end
  endtask

  task automatic test_auto_repeat();
    int p = -1, reps = 0, steps = 0, first_rep = -1, last_rep = -1;
    for (int i = 0; i < 10 && p < 0; i++) begin
      tick(1'b1, 1'b0);
      if (press_pulse === 1'b1) begin p = edge_n; steps++; end
    end
    n_vec++;
    if (p < 0) begin
      n_err++; $display("FAIL repeat_no_press: got none want press within 10 edges");
    end else begin
      while (edge_n < p + 38) begin
        tick(1'b1, 1'b0);
        n_vec++;
        if (got() !== want()) begin
          n_err++; $display("FAIL repeat_model edge %0d: got %b want %b", edge_n, got(), want());
        end
        if (repeat_pulse === 1'b1) begin
          reps++;
          if (first_rep < 0) first_rep = edge_n - p;
          last_rep = edge_n - p;
        end
        if (step === 1'b1) steps++;
        if (edge_n == p + 9 || edge_n == p + 10) begin
          n_vec++;
          if (held !== (edge_n == p + 10)) begin
            n_err++; $display("FAIL repeat_held P+%0d: got %b want %b", edge_n - p, held,
                              edge_n == p + 10);
          end
        end
      end
      n_vec++;
      if ({reps, steps, first_rep, last_rep} !== {32'd10, 32'd11, 32'd10, 32'd37}) begin
        n_err++; $display("FAIL repeat_counts: got reps=%0d steps=%0d first=%0d last=%0d want 10 11 10 37",
                          reps, steps, first_rep, last_rep);
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL repeat_model edge %0d: got %b want %b", edge_n, got(), want());
      end
    end
  endtask

  task automatic test_release_on_expiry();
    int p = -1;
    for (int i = 0; i < 10 && p < 0; i++) begin
      tick(1'b1, 1'b0);
      if (press_pulse === 1'b1) p = edge_n;
    end
    n_vec++;
    if (p < 0) begin
      n_err++; $display("FAIL expiry_no_press: got none want press within 10 edges");
    end else begin
      while (edge_n < p + 10) tick(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
        tick(1'b0, 1'b0);
        n_vec++;
        if (got() !== want()) begin
          n_err++; $display("FAIL expiry_model edge %0d: got %b want %b", edge_n, got(), want());
        end
        if (edge_n == p + 13) begin
          n_vec++;
          if (repeat_pulse !== 1'b1) begin
            n_err++; $display("FAIL expiry_prior_repeat: got %b want 1", repeat_pulse);
          end
        end
        if (edge_n == p + 16) begin
          n_vec++;
          if ({release_pulse, repeat_pulse, held, step} !== 4'b1000) begin
            n_err++; $display("FAIL expiry_release: got %b%b%b%b want 1000", release_pulse,
                              repeat_pulse, held, step);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    int p = -1;
    for (int i = 0; i < 10 && p < 0; i++) begin
      tick(1'b1, 1'b0);
      if (press_pulse === 1'b1) p = edge_n;
    end
    n_vec++;
    if (p < 0) begin
      n_err++; $display("FAIL midrst_no_press: got none want press within 10 edges");
    end else begin
      while (edge_n < p + 13) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      n_vec++;
      if (got() !== 6'b0) begin
        n_err++; $display("FAIL midrst_outputs: got %b want %b", got(), 6'b0);
      end
      for (int i = 1; i <= 8; i++) begin
        tick(1'b1, 1'b0);
        n_vec++;
        if ({press_pulse, release_pulse} !== {i == 6, 1'b0}) begin
          n_err++; $display("FAIL midrst_repress edge %0d: got %b%b want %b0", i, press_pulse,
                            release_pulse, i == 6);
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      n_vec++;
      if (got() !== want()) begin
        n_err++; $display("FAIL midrst_model edge %0d: got %b want %b", edge_n, got(), want());
      end
    end
  endtask

  task automatic test_random();
    logic v, r;
    int   len;
    for (int s = 0; s < 80; s++) begin
      v   = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) begin
        r = ($urandom_range(0, 99) == 0);
        tick(v, r);
        n_vec++;
        if (got() !== want()) begin
          n_err++; $display("FAIL random edge %0d: got %b want %b", edge_n, got(), want());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_on_expiry();
    test_reset_mid_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
